// File: rtl/bitstream_eval_if.sv
// Handshake and data bundle between the layer evaluation controller, the
// network sequencer and one bitstream neuron layer.
interface bitstream_eval_if #(
    parameter int NUM_NEURONS = 4,
    parameter int COUNT_W     = 9
);
    logic                           start_valid;
    logic                           start_ready;
    logic                           abort;
    logic [NUM_NEURONS-1:0]         layer_out;
    logic                           layer_n_rst;
    logic                           busy;
    logic [NUM_NEURONS*COUNT_W-1:0] counts;
    logic                           result_valid;
    logic                           result_ready;

    modport master (
        output start_valid, abort, layer_out, result_ready,
        input  start_ready, layer_n_rst, busy, counts, result_valid
    );

    modport slave (
        input  start_valid, abort, layer_out, result_ready,
        output start_ready, layer_n_rst, busy, counts, result_valid
    );
endinterface

// File: rtl/bitstream_eval_ctrl.sv
// Runs one evaluation window of a bitstream neuron layer: hold in reset,
// skip warm-up bits, count ones per neuron, then hand the counts over.
module bitstream_eval_ctrl #(
    parameter int NUM_NEURONS  = 4,
    parameter int STREAM_LEN   = 256,
    parameter int WARMUP       = 2,
    parameter int CLEAR_CYCLES = 2,
    parameter int COUNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    bitstream_eval_if.slave bus
);
    localparam int PH_MAX_CW = (CLEAR_CYCLES > WARMUP) ? CLEAR_CYCLES : WARMUP;
    localparam int PH_MAX    = (PH_MAX_CW > STREAM_LEN) ? PH_MAX_CW : STREAM_LEN;
    localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] CLEAR_LAST = PH_W'(CLEAR_CYCLES - 1);
    localparam logic [PH_W-1:0] WARM_LAST  = PH_W'((WARMUP > 0) ? WARMUP - 1 : 0);
    localparam logic [PH_W-1:0] RUN_LAST   = PH_W'(STREAM_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [PH_W-1:0]    phase_r;
    logic               phase_last_s;
    logic               start_fire_s;
    logic               abort_fire_s;
    logic               layer_n_rst_s;
    logic               busy_s;
    logic               result_valid_s;
    logic               layer_n_rst_r;
    logic               busy_r;
    logic               result_valid_r;
    logic [COUNT_W-1:0] count_r [NUM_NEURONS];

    assign bus.start_ready = (state_r == ST_IDLE) && !bus.abort;
    assign start_fire_s    = bus.start_valid && bus.start_ready;
    assign abort_fire_s    = bus.abort && (state_r != ST_IDLE);

    // The phase counter restarts on every state change, so "last" is a per-state compare.
    always_comb begin
        phase_last_s = 1'b0;
        case (state_r)
            ST_CLEAR:  phase_last_s = (phase_r == CLEAR_LAST);
            ST_WARMUP: phase_last_s = (phase_r == WARM_LAST);
            ST_RUN:    phase_last_s = (phase_r == RUN_LAST);
            default:   phase_last_s = 1'b0;
        endcase
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        next_state_s = state_r;
        if (abort_fire_s) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_state_s = start_fire_s ? ST_CLEAR : ST_IDLE;
                ST_CLEAR:  next_state_s = !phase_last_s ? ST_CLEAR :
                                          ((WARMUP > 0) ? ST_WARMUP : ST_RUN);
                ST_WARMUP: next_state_s = phase_last_s ? ST_RUN : ST_WARMUP;
                ST_RUN:    next_state_s = phase_last_s ? ST_HOLD : ST_RUN;
                ST_HOLD:   next_state_s = bus.result_ready ? ST_IDLE : ST_HOLD;
                default:   next_state_s = ST_IDLE;
            endcase
        end
    end

    // State and phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            phase_r <= {PH_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            if ((next_state_s != state_r) || (state_r == ST_IDLE) || (state_r == ST_HOLD)) begin
                phase_r <= {PH_W{1'b0}};
            end else begin
                phase_r <= phase_r + {{(PH_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Outputs are decoded from the upcoming state so they register cleanly.
    always_comb begin
        layer_n_rst_s  = (next_state_s == ST_WARMUP) || (next_state_s == ST_RUN);
        busy_s         = (next_state_s != ST_IDLE);
        result_valid_s = (next_state_s == ST_HOLD);
    end

    // Output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            layer_n_rst_r  <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            layer_n_rst_r  <= layer_n_rst_s;
            busy_r         <= busy_s;
            result_valid_r <= result_valid_s;
        end
    end

    // Per-neuron ones counters: cleared on accept/abort/reset, accumulate in RUN.
    always_ff @(posedge clk) begin
        if (rst || abort_fire_s || start_fire_s) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                count_r[i] <= {COUNT_W{1'b0}};
            end
        end else if (state_r == ST_RUN) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                count_r[i] <= count_r[i] + COUNT_W'(bus.layer_out[i]);
            end
        end
    end

    assign bus.layer_n_rst  = layer_n_rst_r;
    assign bus.busy         = busy_r;
    assign bus.result_valid = result_valid_r;

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_counts
        assign bus.counts[g*COUNT_W +: COUNT_W] = count_r[g];
    end
endmodule
